// File: rtl/fp_pkg.sv
// Shared opcode, latency and behavioural FP32 hook definitions for the multi-op pipe.
// Denormal inputs and results are flushed to zero; rounding is round-to-nearest-even.
package fp_pkg;

  localparam int FP_W = 32;
  localparam logic [31:0] UGT_TRUE  = 32'h0000_0001;
  localparam logic [31:0] UGT_FALSE = 32'h0000_0000;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    FP_ADD = 3'd0,
    FP_SUB = 3'd1,
    FP_MUL = 3'd2,
    FP_NEG = 3'd3,
    FP_UGT = 3'd4
  } fp_op_e;

  function automatic int max_lat(input int l0, input int l1, input int l2, input int l3, input int l4);
    int m;
    m = l0;
    if (l1 > m) m = l1;
    if (l2 > m) m = l2;
    if (l3 > m) m = l3;
    if (l4 > m) m = l4;
    return m;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic int op_latency(input logic [2:0] op, input int l_add, input int l_sub,
                                    input int l_mul, input int l_neg, input int l_ugt);
    int l;
    case (op)
      FP_ADD:  l = l_add;
      FP_SUB:  l = l_sub;
      FP_MUL:  l = l_mul;
      FP_NEG:  l = l_neg;
      FP_UGT:  l = l_ugt;
      default: l = 0;
    endcase
    return l;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // m: [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky
  function automatic logic [31:0] fp_round_pack(input logic s, input int e, input logic [26:0] m);
    logic [24:0] r;
    logic        up;
    int          ee;
    ee = e;
    up = m[2] && (m[1] || m[0] || m[3]);
    r  = {1'b0, m[26:3]} + {24'd0, up};
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 255) return {s, 8'hFF, 23'd0};
    if (ee <= 0) return {s, 31'd0};
    return {s, ee[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] add_f32_hw(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my;
    logic [27:0] sum;
    logic        sticky;
    int          d, e;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0)) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = int'(x[30:23]) - int'(y[30:23]);
    if (d > 26) begin
      my = 27'd1;
    end else if (d > 0) begin
      sticky = |(my & ((27'd1 << d) - 27'd1));
      my     = (my >> d) | {26'd0, sticky};
    end
    e = int'(x[30:23]);
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      if (sum == 28'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 1;
        end
      end
    end
    return fp_round_pack(x[31], e, sum[26:0]);
  endfunction

  function automatic logic [31:0] sub_f32_hw(input logic [31:0] a, input logic [31:0] b);
    return add_f32_hw(a, {~b[31], b[30:0]});
  endfunction

  function automatic logic [31:0] mul_f32_hw(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [26:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && (b[30:23] == 8'd0)) || (is_inf(b) && (a[30:23] == 8'd0))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = {p[47:22], |p[21:0]};
      e = e + 1;
    end else begin
      m = {p[46:21], |p[20:0]};
    end
    return fp_round_pack(s, e, m);
  endfunction

  function automatic logic [31:0] neg_f32_hw(input logic [31:0] a);
    return {~a[31], a[30:0]};
  endfunction

  // Unordered-greater: true when either operand is NaN or a > b; +0 and -0 compare equal.
  function automatic logic [31:0] ugt_f32_hw(input logic [31:0] a, input logic [31:0] b);
    logic gt;
    if (is_nan(a) || is_nan(b))                      gt = 1'b1;
    else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) gt = 1'b0;
    else if (a[31] != b[31])                         gt = b[31];
    else if (!a[31])                                 gt = a[30:0] > b[30:0];
    else                                             gt = a[30:0] < b[30:0];
    return gt ? UGT_TRUE : UGT_FALSE;
  endfunction

endpackage

// File: rtl/fp_slot_pipe.sv
// Shifting completion-slot array: slot 1 is the output head, each slot moves one
// step toward it per clock, and a one-hot insert writes the slot freed by the shift.
module fp_slot_pipe #(
  parameter int DEPTH = 5,
  parameter int DW    = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DEPTH:1]   ins_sel,
  input  logic [DW-1:0]    ins_data,
  output logic [DEPTH:1]   occ,
  output logic             head_valid,
  output logic [DW-1:0]    head_data
);

  logic [DW-1:0]    data_q  [1:DEPTH];
  logic [DW-1:0]    data_up [1:DEPTH+1];
  logic [DEPTH+1:1] occ_up;

  // Virtual slot DEPTH+1 is always empty so the top slot drains uniformly.
  always_comb begin
    occ_up = {1'b0, occ};
    for (int i = 1; i <= DEPTH; i++) data_up[i] = data_q[i];
    data_up[DEPTH+1] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
      for (int i = 1; i <= DEPTH; i++) data_q[i] <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      for (int i = 1; i <= DEPTH; i++) begin
        if (ins_sel[i]) begin
          occ[i]    <= 1'b1;
          data_q[i] <= ins_data;
        end else begin
          occ[i]    <= occ_up[i+1];
          data_q[i] <= data_up[i+1];
        end
      end
    end
  end

  assign head_valid = occ[1];
  assign head_data  = data_q[1];

endmodule

// File: rtl/fp_multi_op_pipe.sv
// Multi-operation FP32 issue pipe: per-op fixed latency, results leave in completion
// order with their request tag, and same-cycle completion collisions back-pressure issue.
module fp_multi_op_pipe
  import fp_pkg::*;
#(
  parameter int LAT_ADD = 5,
  parameter int LAT_SUB = 5,
  parameter int LAT_MUL = 4,
  parameter int LAT_NEG = 1,
  parameter int LAT_UGT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic [2:0]       op,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             ready,
  output logic [31:0]      out,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_illegal
);

  localparam int MAXL = max_lat(LAT_ADD, LAT_SUB, LAT_MUL, LAT_NEG, LAT_UGT);
  localparam int DW   = FP_W + TAG_W;

  if (LAT_ADD < 1 || LAT_ADD > 16 || LAT_SUB < 1 || LAT_SUB > 16 ||
      LAT_MUL < 1 || LAT_MUL > 16 || LAT_NEG < 1 || LAT_NEG > 16 ||
      LAT_UGT < 1 || LAT_UGT > 16) begin : g_bad_latency
    $fatal(1, "fp_multi_op_pipe: every latency must be in 1..16");
  end

  logic            legal;
  logic            accept;
  int              lat_sel;
  logic [31:0]     res;
  logic [MAXL:1]   occ;
  logic [MAXL:1]   ins_sel;
  logic [MAXL+1:1] occ_x;
  logic            head_valid;
  logic [DW-1:0]   head_data;

  // Handshake: a request transfers on a rising edge where t && ready. ready depends only
  // on op and slot occupancy, never on t; the requester holds op/a/b/tag until transfer
  // or may withdraw t while ready is low without any commitment.
  always_comb begin
    legal   = op_legal(op);
    lat_sel = op_latency(op, LAT_ADD, LAT_SUB, LAT_MUL, LAT_NEG, LAT_UGT);
    case (op)
      FP_ADD:  res = add_f32_hw(a, b);
      FP_SUB:  res = sub_f32_hw(a, b);
      FP_MUL:  res = mul_f32_hw(a, b);
      FP_NEG:  res = neg_f32_hw(a);
      FP_UGT:  res = ugt_f32_hw(a, b);
      default: res = 32'd0;
    endcase
    occ_x = {1'b0, occ};
    ready = 1'b0;
    for (int i = 1; i <= MAXL; i++) begin
      if (legal && (lat_sel == i)) ready = !occ_x[i+1];
    end
    accept  = t && ready;
    ins_sel = '0;
    for (int i = 1; i <= MAXL; i++) ins_sel[i] = accept && (lat_sel == i);
  end

  fp_slot_pipe #(
    .DEPTH(MAXL),
    .DW   (DW)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ins_sel   (ins_sel),
    .ins_data  ({res, tag}),
    .occ       (occ),
    .head_valid(head_valid),
    .head_data (head_data)
  );

  assign out_valid = head_valid;
  assign out       = head_valid ? head_data[DW-1:TAG_W] : 32'd0;
  assign out_tag   = head_valid ? head_data[TAG_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              err_illegal <= 1'b0;
    else if (t && !legal)  err_illegal <= 1'b1;
  end

endmodule

// File: doc/fp_multi_op_pipe.md
Name: fp_multi_op_pipe

Overview:
- Parametrised multi-operation FP32 pipeline; the next generation of the per-op fixed-delay FP helpers.
- One issue port accepts add/sub/mul/neg/ugt with per-op programmable latency, a valid/tag sideband and structural-hazard back-pressure.
- Sits between HIR-generated datapaths and the behavioural FP hook functions (add_f32_hw, sub_f32_hw, mul_f32_hw, neg_f32_hw, ugt_f32_hw).
- Results emerge in completion order, with the tag of the issuing request.

Parameters:
- LAT_ADD, 5, cycles from accepted issue to out_valid for add (1..16)
- LAT_SUB, 5, same for sub
- LAT_MUL, 4, same for mul
- LAT_NEG, 1, same for neg
- LAT_UGT, 1, same for ugt
- TAG_W, 4, width of request tag carried to the output

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- t  in  1  issue valid
- op  in  3  opcode: 0 add, 1 sub, 2 mul, 3 neg, 4 ugt, 5..7 illegal
- a  in  32  operand A (IEEE-754 single)
- b  in  32  operand B (ignored for neg)
- tag  in  TAG_W  request tag
- flush  in  1  synchronous clear of all in-flight results
- ready  out  1  combinational: issue of current op would be accepted
- out  out  32  result
- out_valid  out  1  result valid this cycle
- out_tag  out  TAG_W  tag of the result
- err_illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-to-clk deassert use): out=0, out_valid=0, out_tag=0, err_illegal=0, all slots invalid. Reset mid-operation discards every in-flight result; none ever appears.
- Localparam MAXL = max of the five latencies. Slot array S[1..MAXL], each slot holds {valid, data[31:0], tag}.
- Result is computed combinationally at issue from the hook function for op. ugt result is zero-extended: 0x00000001 if a>b unordered-greater, else 0x00000000.
- Accept condition: t && ready. ready = legal(op) && (L(op)==MAXL || !S[L(op)+1].valid).
- Each clock: S[i] <= S[i+1] for i<MAXL; S[MAXL] <= invalid. On accept, the new entry overwrites S[L(op)] (the slot freed by the shift). The ready rule guarantees that slot is empty.
- Outputs are registered from S[1]: out_valid=S[1].valid, out=S[1].data when valid else 0, out_tag likewise gated to 0.
- Latency: issue accepted at edge k gives out_valid high in the cycle after edge k+L-1, i.e. exactly L cycles later.
- Throughput: one accept per cycle when no collision. Same-op back-to-back is never blocked.
- Collision: a shorter-latency op issued after a longer one whose completion coincides sees ready=0. The requester holds t, op, a, b and tag until accepted. A dropped t while ready=0 is allowed (no commitment).
- Illegal op (5..7): ready=0. If t=1 with an illegal op, err_illegal sets on the next edge and stays set until reset. Nothing is inserted.
- flush=1: all slots invalid on next edge; out_valid=0 the following cycle. An issue in the same cycle as flush is also discarded, though ready still reflects pre-flush state.
- Parameter check at elaboration: every latency must be in 1..16, otherwise fatal.

Decomposition:
- Package fp_pkg:
  - opcode constants/enum (FP_ADD..FP_UGT)
  - FP32 width constant
  - function max_lat(...)
  - function op_latency(op) mapping
  - ugt true/false constants
- Sub-module fp_slot_pipe (parameters DEPTH, DW): shifting slot array with indexed insert port and occupancy vector output; the top instantiates it with DW=32+TAG_W.

Test Plan:
- Add 0x3F800000 + 0x40000000, tag 3, issued at cycle 0 -> out=0x40400000, out_tag=3, out_valid only in cycle 5.
- Mul 0x40000000 * 0x40400000 at cycle 0, then neg 0x3F800000 at cycle 1 -> 0x40C00000 at cycle 4, 0xBF800000 at cycle 2; out_valid high exactly those two cycles.
- Collision: add at cycle 0, mul at cycle 1 -> ready=0 at cycle 1; mul held, accepted cycle 2 -> add result cycle 5, mul result cycle 6.
- Back-to-back ugt (0x40000000,0x3F800000), (0x3F800000,0x40000000) at cycles 0,1 -> out 0x00000001 cycle 1, 0x00000000 cycle 2.
- Three adds in flight, rst low for one cycle at cycle 2 -> all outputs 0 immediately, no out_valid thereafter; a new add at cycle 4 yields a result at cycle 9.
- t=1, op=6 -> ready=0, err_illegal=1 from next cycle until reset, no out_valid; a flush with two muls in flight -> no results.
